vend_dispense_scheduler: RTL

- Shares one dispense actuator (product motor plus change-coin ejector) between N_CH vending channels.
- Each channel runs its own coin FSM and raises a dispense request with a change-owed flag.
- This block grants one channel at a time in round-robin order and sequences the motor.
- It waits for the chute drop sensor, pulses change return when owed, and flags a fault on timeout.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_rr_arbiter.sv | 38 +++
 rtl/vend_dispense_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and timing defaults for the vending dispense scheduler.
// The counter-width helper sizes one counter to cover every timed phase.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOTOR     = 3'd1,
    WAIT_DROP = 3'd2,
    CHANGE    = 3'd3,
    DONE      = 3'd4,
    FAULT     = 3'd5
  } vend_state_t;

  localparam int DEF_N_CH      = 4;
  localparam int DEF_MOTOR_CYC = 8;
  localparam int DEF_DROP_TO   = 32;
  localparam int DEF_CHG_CYC   = 2;

  function automatic int cnt_width(input int motor_cyc, input int drop_to, input int chg_cyc);
    int m;
    m = motor_cyc;
    if (drop_to > m) m = drop_to;
    if (chg_cyc > m) m = chg_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after i_ptr,
// wrapping modulo N_CH. o_valid is low when no channel requests.
module vend_rr_arbiter
  import vend_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_CH-1:0]  o_onehot,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_sum    = '0;
    w_cand   = '0;
    for (int i = 0; i < N_CH; i++) begin
      // i_ptr < N_CH and i < N_CH, so a single subtraction wraps the sum.
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(N_CH)) w_sum = w_sum - (PTR_W+1)'(N_CH);
      w_cand = w_sum[PTR_W-1:0];
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Grants the shared dispense actuator to one channel at a time, runs the motor,
// waits for the chute drop sensor, ejects change when owed, and locks on timeout.
module vend_dispense_scheduler
  import vend_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int MOTOR_CYC = DEF_MOTOR_CYC,
  parameter int DROP_TO   = DEF_DROP_TO,
  parameter int CHG_CYC   = DEF_CHG_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH-1:0]   i_req,
  input  logic [N_CH-1:0]   i_req_chg,
  input  logic              i_fault_clr,
  input  logic              i_drop_det,
  output logic [N_CH-1:0]   o_grant,
  output logic              o_motor_on,
  output logic              o_coin_out,
  output logic              o_done,
  output logic              o_fault,
  output logic              o_busy,
  output vend_state_t       o_dbg_state
);

  localparam int CNT_W = cnt_width(MOTOR_CYC, DROP_TO, CHG_CYC);
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  vend_state_t      r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [PTR_W-1:0] r_ptr, w_ptr_next, r_idx, w_idx_next, w_ptr_inc;
  logic [N_CH-1:0]  r_grant, w_grant_next;
  logic             r_chg_l, w_chg_next, r_drop_seen, w_drop_next;
  logic             r_motor_on, r_coin_out, r_done, r_fault, r_busy;
  logic [N_CH-1:0]  w_arb_onehot;
  logic [PTR_W-1:0] w_arb_idx;
  logic             w_arb_valid;

  vend_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_arb_onehot),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  assign w_ptr_inc = (r_idx == PTR_W'(N_CH-1)) ? '0 : r_idx + PTR_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_idx_next   = r_idx;
    w_grant_next = r_grant;
    w_chg_next   = r_chg_l;
    w_drop_next  = r_drop_seen;
    case (r_state)
      IDLE: if (w_arb_valid) begin
        w_state_next = MOTOR;
        w_cnt_next   = '0;
        w_idx_next   = w_arb_idx;
        w_grant_next = w_arb_onehot;
        w_chg_next   = i_req_chg[w_arb_idx];
        w_drop_next  = 1'b0;
      end
      MOTOR: begin
        w_drop_next = r_drop_seen | i_drop_det;
        if (r_cnt == CNT_W'(MOTOR_CYC-1)) begin
          w_state_next = WAIT_DROP;
          w_cnt_next   = '0;
        end else w_cnt_next = r_cnt + CNT_W'(1);
      end
      WAIT_DROP: begin
        if (r_drop_seen || i_drop_det) begin
          w_state_next = r_chg_l ? CHANGE : DONE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(DROP_TO-1)) begin
          w_state_next = FAULT;
          w_cnt_next   = '0;
        end else w_cnt_next = r_cnt + CNT_W'(1);
      end
      CHANGE: begin
        if (r_cnt == CNT_W'(CHG_CYC-1)) begin
          w_state_next = DONE;
          w_cnt_next   = '0;
        end else w_cnt_next = r_cnt + CNT_W'(1);
      end
      DONE: begin
        w_state_next = IDLE;
        w_grant_next = '0;
        w_ptr_next   = w_ptr_inc;
      end
      FAULT: if (i_fault_clr) begin
        w_state_next = IDLE;
        w_grant_next = '0;
        w_ptr_next   = w_ptr_inc;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_grant     <= '0;
      r_chg_l     <= 1'b0;
      r_drop_seen <= 1'b0;
      r_motor_on  <= 1'b0;
      r_coin_out  <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_ptr       <= w_ptr_next;
      r_idx       <= w_idx_next;
      r_grant     <= w_grant_next;
      r_chg_l     <= w_chg_next;
      r_drop_seen <= w_drop_next;
      r_motor_on  <= (w_state_next == MOTOR);
      r_coin_out  <= (w_state_next == CHANGE);
      r_done      <= (w_state_next == DONE);
      r_fault     <= (w_state_next == FAULT);
      r_busy      <= (w_state_next != IDLE);
    end
  end

  assign o_grant     = r_grant;
  assign o_motor_on  = r_motor_on;
  assign o_coin_out  = r_coin_out;
  assign o_done      = r_done;
  assign o_fault     = r_fault;
  assign o_busy      = r_busy;
  assign o_dbg_state = r_state;

endmodule
